bch_rx_framer: RTL
==================

BCH_RX_FRAMER -- requirements
Module: bch_rx_framer

Interface
REQ-001 Parameter: GEN_POLY, default 9'h1D1, generator g(x) = x^8+x^7+x^6+x^4+1 of the BCH(15,7) code.
REQ-002 Parameter: OVR_W, default 8, width of the overrun counter.
REQ-003 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port: rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 Port: ena, input, 1, block enable; when low, bit_valid and sof are ignored and no state changes except output handshake.
REQ-006 Port: bit_in, input, 1, serial received bit, MSB-first (codeword bit 14 first, parity bit 0 last).
REQ-007 Port: bit_valid, input, 1, bit_in is valid this cycle; no backpressure, the block is always ready.
REQ-008 Port: sof, input, 1, start-of-frame marker, qualified by bit_valid.
REQ-009 Port: word_out, output, 15, assembled received word {msg[6:0], parity[7:0]} for the downstream decoder.
REQ-010 Port: rem_out, output, 8, remainder of word_out mod g(x).
REQ-011 Port: err_flag, output, 1, high when rem_out != 0.
REQ-012 Port: word_valid, output, 1, output register holds an undelivered word.
REQ-013 Port: word_ready, input, 1, downstream accepts the word when word_valid and word_ready are both high.
REQ-014 Port: overrun, output, 1, one-cycle pulse when a completed word is dropped.
REQ-015 Port: frame_err, output, 1, one-cycle pulse when sof truncates a partial frame.
REQ-016 Port: ovr_cnt, output, OVR_W, saturating count of dropped words.
REQ-017 Port: bit_cnt, output, 4, number of bits of the current frame accepted so far (0..14).

Function
REQ-018 Accepted bit: ena & bit_valid high at a rising edge.
REQ-019 Shift register: sh <= {sh[13:0], bit_in} on each accepted bit.
REQ-020 Remainder LFSR: r <= {r[6:0], bit_in} ^ (r[7] ? GEN_POLY[7:0] : 8'h00) on each accepted bit; after 15 bits from r = 0, r equals the word mod g(x).
REQ-021 Counter: bit_cnt increments on each accepted bit; the accepted bit at bit_cnt == 14 completes the frame and bit_cnt wraps to 0.
REQ-022 Frame start: an accepted bit with sof high is codeword bit 14; the LFSR restarts as if r = 0, sh restarts, and bit_cnt becomes 1.
REQ-023 Frame error: if sof is accepted while bit_cnt != 0, the partial frame is discarded and frame_err pulses in the following cycle.
REQ-024 Frame completion: on the completing bit, the word {sh[13:0], bit_in} and the final r are computed combinationally and offered to the output register.
REQ-025 Output register load: the register loads if word_valid is low, or if word_valid & word_ready are high in the same cycle; word_valid is then high the next cycle.
REQ-026 Latency: word_valid rises exactly 1 cycle after the completing bit is accepted.
REQ-027 Output stability: while word_valid is high and word_ready is low, word_out, rem_out and err_flag hold stable.
REQ-028 Handshake clear: if word_valid & word_ready are high and no new word completes, word_valid falls the next cycle.
REQ-029 Overrun: if the register cannot load (word_valid high, word_ready low), the new word is dropped and the held word is kept.
REQ-030 Overrun reporting: on a drop, overrun pulses next cycle and ovr_cnt increments, saturating at all-ones.
REQ-031 Back-to-back frames: frames with no idle cycles between them are supported; the sof bit may directly follow the completing bit.
REQ-032 Ungated handshake: word_ready handling is independent of ena.

Reset
REQ-033 rst_n low asynchronously clears sh, r, bit_cnt, the output register (word_out = 0, rem_out = 0, err_flag = 0), word_valid, overrun, frame_err and ovr_cnt.
REQ-034 A frame in progress during reset is lost; after rst_n deasserts, the first accepted bit is treated as bit 14 regardless of sof.

Verification
REQ-035 Clean word: serialize 15'h40E8 with sof on the first bit, word_ready = 1 -> one cycle after the 15th bit, word_valid = 1, word_out = 15'h40E8, rem_out = 8'h00, err_flag = 0.
REQ-036 Single-bit errors: serialize 15'h40E9 -> rem_out = 8'h01, err_flag = 1; serialize 15'h00E8 (bit 14 flipped) -> rem_out = 8'hE8.
REQ-037 Stall and overrun: hold word_ready = 0 across two complete frames (15'h40E8 then 15'h0000) -> word_out stays 15'h40E8, overrun pulses once, ovr_cnt = 1; then word_ready = 1 -> word_valid falls.
REQ-038 Truncated frame: send 6 bits, then sof plus 15 bits of 15'h40E8 -> frame_err pulses once, and the delivered word is 15'h40E8 with rem_out = 8'h00.
REQ-039 Reset mid-frame and saturation: assert rst_n low after 9 bits -> all outputs 0; force 300 overruns -> ovr_cnt = 8'hFF and does not wrap.

Source files
------------

// File: rtl/bch_rx_framer_if.sv
// Serial-in / word-out bus of the BCH(15,7) receive framer.
// The bit stream is carried from the line side and the assembled word is offered downstream.
interface bch_rx_framer_if;
  logic        bit_in;
  logic        bit_valid;
  logic        sof;
  logic [14:0] word_out;
  logic [7:0]  rem_out;
  logic        err_flag;
  logic        word_valid;
  logic        word_ready;

  // Framer side: consumes bits, produces words.
  modport slave (
    input  bit_in,
    input  bit_valid,
    input  sof,
    input  word_ready,
    output word_out,
    output rem_out,
    output err_flag,
    output word_valid
  );

  // Environment side: drives bits, consumes words.
  modport master (
    output bit_in,
    output bit_valid,
    output sof,
    output word_ready,
    input  word_out,
    input  rem_out,
    input  err_flag,
    input  word_valid
  );
endinterface

// File: rtl/bch_rx_framer.sv
// BCH(15,7) receive framer: deserializes MSB-first codewords, computes the remainder
// modulo g(x) on the fly and hands complete words to a valid/ready output register.
module bch_rx_framer #(
  parameter logic [8:0]  GEN_POLY = 9'h1D1,
  parameter int unsigned OVR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  bch_rx_framer_if.slave   bus,
  output logic             overrun,
  output logic             frame_err,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic [3:0]       bit_cnt
);

  localparam logic [3:0] LastBit = 4'd14;

  logic [13:0]      sh_q, sh_d;
  logic [7:0]       r_q, r_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [14:0]      word_q, word_d;
  logic [7:0]       rem_q, rem_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;

  logic        accept;
  logic        start;
  logic [13:0] sh_base;
  logic [7:0]  r_base;
  logic [3:0]  cnt_base;
  logic [7:0]  r_shift;
  logic        complete;
  logic        load_ok;

  // Bit-level datapath: shift register, remainder LFSR and frame position counter.
  always_comb begin
    accept   = ena & bus.bit_valid;
    // A frame starts on sof or on any bit taken while no frame is open.
    start    = bus.sof | (cnt_q == 4'd0);
    sh_base  = start ? 14'd0 : sh_q;
    r_base   = start ? 8'd0 : r_q;
    cnt_base = start ? 4'd0 : cnt_q;
    r_shift  = {r_base[6:0], bus.bit_in} ^ (r_base[7] ? GEN_POLY[7:0] : 8'h00);
    complete = accept & (cnt_base == LastBit);

    sh_d        = sh_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    if (accept) begin
      sh_d        = {sh_base[12:0], bus.bit_in};
      r_d         = r_shift;
      cnt_d       = complete ? 4'd0 : cnt_base + 4'd1;
      frame_err_d = bus.sof & (cnt_q != 4'd0);
    end
  end

  // Output register: load a completed word when free or being drained, else drop it.
  always_comb begin
    load_ok   = ~valid_q | bus.word_ready;
    word_d    = word_q;
    rem_d     = rem_q;
    err_d     = err_q;
    valid_d   = valid_q & ~bus.word_ready;
    overrun_d = 1'b0;
    ovr_cnt_d = ovr_cnt_q;
    if (complete) begin
      if (load_ok) begin
        word_d  = {sh_base, bus.bit_in};
        rem_d   = r_shift;
        err_d   = |r_shift;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
        ovr_cnt_d = (ovr_cnt_q == {OVR_W{1'b1}}) ? ovr_cnt_q : ovr_cnt_q + OVR_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ovr_cnt_q   <= '0;
    end else begin
      sh_q        <= sh_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      ovr_cnt_q   <= ovr_cnt_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.rem_out    = rem_q;
  assign bus.err_flag   = err_q;
  assign bus.word_valid = valid_q;
  assign overrun        = overrun_q;
  assign frame_err      = frame_err_q;
  assign ovr_cnt        = ovr_cnt_q;
  assign bit_cnt        = cnt_q;

endmodule
